cache_controller: RTL
=====================

# cache_controller

Direct-mapped read-only cache controller between the CPU word-read port and `MainMemory`. It holds 256 lines of 4 words each, with tag/valid storage and line data. On a hit it returns the word without touching memory. On a miss it sequences a block fetch from `MainMemory` through its read/dataReady handshake, then fills the line and answers the CPU.

## Interface
Parameters:
- `ADDR_W`, 15: word address width; must match the `MainMemory` address.
- `INDEX_W`, 8: line index width (256 lines); tag width is `ADDR_W-INDEX_W-2`.
- `CNT_W`, 16: statistics counter width (used only with `CACHE_STATS_EN`).

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `cpu_req`, in, 1: read request; held high with `cpu_addr` stable until `cpu_ready`.
- `cpu_addr`, in, `ADDR_W`: word address. Fields are tag [14:10], index [9:2], offset [1:0].
- `cpu_ready`, out, 1: one-cycle pulse; `cpu_data` valid.
- `cpu_data`, out, 32: returned word, held until the next `cpu_ready`.
- `cpu_hit`, out, 1: qualifies `cpu_ready`; 1 = hit, 0 = filled from memory.
- `flush`, in, 1: invalidate all lines.
- `mem_read`, out, 1: level request to `MainMemory`; a rising edge starts a fetch.
- `mem_addr`, out, `ADDR_W`: block base, {tag, index, 2'b00}.
- `mem_ready`, in, 1: `MainMemory` dataReady.
- `mem_block`, in, 128: fetched block; word k is in bits [32k+31:32k].
- `hit_count`, out, `CNT_W`: hits (`CACHE_STATS_EN` only).
- `miss_count`, out, `CNT_W`: misses (`CACHE_STATS_EN` only).

## Operation
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESPOND.
- IDLE:
  - `flush`=1 clears all valid bits in one cycle and stays in IDLE. Flush wins over a simultaneous `cpu_req`; the request is served next cycle.
  - Else `cpu_req`=1 latches the address and goes to LOOKUP.
- LOOKUP: hit = valid[index] and tag match.
  - Hit: select word[offset] into `cpu_data`, `cpu_hit`=1, go to RESPOND.
  - Miss: go to MISS_REQ.
- MISS_REQ: drive `mem_addr`, raise `mem_read`, clear the seen-low flag, go to MISS_WAIT.
- MISS_WAIT: keep `mem_read` high.
  - Set seen-low when `mem_ready`=0 is sampled.
  - Move to FILL only when `mem_ready`=1 is sampled with seen-low already set. This ignores a stale dataReady left high by the previous fetch.
  - No timeout.
- FILL: write `mem_block` to data[index], the tag to tag[index], and set valid[index]=1. Drop `mem_read`. Set `cpu_data` = `mem_block` word[offset] and `cpu_hit`=0. Go to RESPOND.
- RESPOND: `cpu_ready`=1 for this cycle only, then IDLE. The requester must drop or change `cpu_req` in the cycle after `cpu_ready`.
- `flush` outside IDLE is ignored. It is not queued.
- Reset values: `cpu_ready`=0, `cpu_data`=0, `cpu_hit`=0, `mem_read`=0, `mem_addr`=0, counters=0. All valid bits=0, state IDLE. Tag and data arrays are not reset.
- Reset asserted mid-fill drops `mem_read` immediately. The in-flight memory response is ignored.

## Timing
- `cpu_req` sampled high in IDLE at edge N:
  - Hit: `cpu_ready` high in cycle N+2.
  - Miss: `mem_read` rises at N+2.
- Miss latency is N+2 + (cycles until `mem_ready` has been seen low then high) + 2 (FILL, RESPOND).
- Back-to-back hits: one every 3 cycles (IDLE, LOOKUP, RESPOND).
- `mem_read` stays high continuously from MISS_REQ through the last MISS_WAIT cycle. It goes low in FILL, so every fetch produces a fresh rising edge.
- `mem_ready` is treated as synchronous to `clk`. It is sampled once per edge.
- A line filled in FILL hits on the very next request to the same block.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each LOOKUP hit; `miss_count` increments on each LOOKUP miss.
  - Both are `CNT_W` bits and saturate at all-ones.
  - `flush` does not clear them; only `rst` does.
- `CACHE_STATS_EN` undefined: counter logic and both ports are absent.

## Structure
- Shared package `cache_pkg` holds:
  - the state enum type;
  - `OFFSET_W`=2, `BLOCK_W`=128, `WORD_W`=32;
  - field-extraction helper functions for tag, index and offset.
- Sub-module `cache_line_store`: tag, valid and data arrays.
  - Combinational read by index.
  - Synchronous line write.
  - Single-cycle valid clear for flush.
  - Asynchronous valid reset.
- The FSM, handshake and counters stay in `cache_controller`.

## Test plan
- Cold miss: after reset, read 0x0005; memory returns word1 = 0xDEADBEEF. Required: `mem_read` rises with `mem_addr`=0x0004, then `cpu_ready` with `cpu_data`=0xDEADBEEF and `cpu_hit`=0.
- Hit after fill: read 0x0006. Required: `cpu_ready` exactly 2 cycles after the request, `cpu_hit`=1, word2 of the cached block returned, `mem_read` stays 0.
- Conflict eviction: read 0x0004, then 0x0404 (same index 1, tag 1), then 0x0004 again. Required: three misses, `miss_count`=3, `hit_count`=0.
- Stale ready: leave `mem_ready` high from the previous fetch, issue a miss, then hold `mem_ready` low 5 cycles before raising it. Required: FILL is entered only after it rises again.
- Flush and simultaneous request: `flush` and `cpu_req` (0x0005, cached) high together in IDLE. Required: valid bits cleared first, then a miss fetch with `cpu_hit`=0.
- Reset mid-fill: assert `rst` low during MISS_WAIT. Required: `mem_read`=0 and `cpu_ready`=0 immediately; after release, a read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped read-only cache.
package cache_pkg;

  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 128;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL,
    S_RESPOND
  } state_e;

  // Helpers take a zero-extended address so they work for any ADDR_W up to 32.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_w);
    return a >> (index_w + OFFSET_W);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_w);
    return (a >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] a);
    return OFFSET_W'(a & 32'd3);
  endfunction

  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] b,
                                                   input logic [OFFSET_W-1:0] off);
    return b[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag, valid and data arrays: combinational read by index, clocked line write,
// single-cycle valid clear. Only the valid bits are reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic               clr
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];
  logic [LINES-1:0]   valid_q;

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q <= valid_q | (LINES'(1) << wr_index);
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped read-only cache controller with MainMemory block-fetch handshake.
// Optional hit/miss statistics counters enabled by defining CACHE_STATS_EN.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int INDEX_W = 8
`ifdef CACHE_STATS_EN
  ,parameter int CNT_W  = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ready,
  output logic [WORD_W-1:0]  cpu_data,
  output logic               cpu_hit,
  input  logic               flush,
  output logic               mem_read,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_block
`ifdef CACHE_STATS_EN
  ,output logic [CNT_W-1:0]  hit_count
  ,output logic [CNT_W-1:0]  miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   cpu_data_q, cpu_data_d;
  logic                cpu_hit_q, cpu_hit_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                seen_low_q, seen_low_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLOCK_W-1:0]  rd_data;
  logic                lookup_hit;
  logic                store_we;
  logic                store_clr;

  assign idx        = INDEX_W'(addr_index(32'(addr_q), INDEX_W));
  assign tag        = TAG_W'(addr_tag(32'(addr_q), INDEX_W));
  assign off        = addr_offset(32'(addr_q));
  assign lookup_hit = rd_valid && (rd_tag == tag);

  cache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (store_we),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (mem_block),
    .clr      (store_clr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cpu_data_q <= '0;
      cpu_hit_q  <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cpu_data_q <= cpu_data_d;
      cpu_hit_q  <= cpu_hit_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      seen_low_q <= seen_low_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cpu_data_d = cpu_data_q;
    cpu_hit_d  = cpu_hit_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    seen_low_d = seen_low_q;
    store_we   = 1'b0;
    store_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          store_clr = 1'b1;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          cpu_data_d = block_word(rd_data, off);
          cpu_hit_d  = 1'b1;
          state_d    = S_RESPOND;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_addr_d = {tag, idx, {OFFSET_W{1'b0}}};
        mem_read_d = 1'b1;
        seen_low_d = 1'b0;
        state_d    = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        // A ready still high from the previous fetch is ignored until it has dropped once.
        if (!mem_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          mem_read_d = 1'b0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        store_we   = 1'b1;
        cpu_data_d = block_word(mem_block, off);
        cpu_hit_d  = 1'b0;
        state_d    = S_RESPOND;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign cpu_ready = (state_q == S_RESPOND);
  assign cpu_data  = cpu_data_q;
  assign cpu_hit   = cpu_hit_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (lookup_hit && !(&hit_cnt_q)) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      if (!lookup_hit && !(&miss_cnt_q)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
